rk_spi_port: RTL and testbench

//  CPU-mapped SPI master for the SD card window (A000h-BFFFh), successor of the
//  bit-bang SD latch. Keeps a legacy bit-bang mode bit-compatible with existing

---
 rtl/rk_spi_port_if.sv | 14 +
 rtl/rk_spi_port.sv | 151 +++++++++++++++
 tb/tb_rk_spi_port.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rk_spi_port_if.sv
// CPU-side register bus of the SD/SPI window: decoded select, register address,
// write/read levels held for the whole bus cycle, and combinational read data.
interface rk_spi_port_if;
  logic       sel;
  logic [1:0] addr;
  logic [7:0] idata;
  logic       we_n;
  logic       rd;
  logic [7:0] odata;
  logic       busy;

  modport master (output sel, addr, idata, we_n, rd, input odata, busy);
  modport slave  (input sel, addr, idata, we_n, rd, output odata, busy);
endinterface

// File: rtl/rk_spi_port.sv
// SPI master for the SD window: legacy bit-bang mode plus a hardware byte mode.
// Byte transfer takes 16*(div+1) clocks; writes arriving while busy are dropped and flagged in ovr.
module rk_spi_port #(
  parameter int NUM_CS      = 1,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 24
) (
  input  logic              clk50mhz,
  input  logic              reset,
  rk_spi_port_if.slave      bus,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  logic              prev_we_n;
  logic              prev_rd;
  logic              wr_stb;
  logic              rd_stb;
  logic              mode;
  logic [NUM_CS-1:0] cs;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  cnt;
  logic [2:0]        bitcnt;
  logic [1:0]        state;
  logic [7:0]        shift;
  logic              done;
  logic              ovr;
  logic              busy;
  logic [5:0]        cs_ext;
  logic [7:0]        div_ext;

  // Edge-detected strobes: one action per CPU cycle however long the level is held.
  assign wr_stb = bus.sel & ~bus.we_n & prev_we_n;
  assign rd_stb = bus.sel & bus.rd & ~prev_rd;

  assign spi_cs_n = ~cs;
  assign bus.busy = busy;

  always_comb begin
    cs_ext = '0;
    cs_ext[NUM_CS-1:0] = cs;
    div_ext = '0;
    div_ext[DIV_W-1:0] = div;
  end

  always_comb begin
    bus.odata = 8'h00;
    case (bus.addr)
      2'd0:    bus.odata = {mode, busy, cs_ext};
      2'd1:    bus.odata = mode ? shift : {shift[6:0], spi_miso};
      2'd2:    bus.odata = div_ext;
      default: bus.odata = {5'b0, ovr, done, busy};
    endcase
  end

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      prev_we_n <= 1'b1;
      prev_rd   <= 1'b0;
      mode      <= 1'b0;
      cs        <= '0;
      div       <= DIV_W'(DEFAULT_DIV);
      cnt       <= '0;
      bitcnt    <= 3'd0;
      state     <= ST_IDLE;
      shift     <= 8'hFF;
      done      <= 1'b0;
      ovr       <= 1'b0;
      busy      <= 1'b0;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b1;
    end else begin
      prev_we_n <= bus.we_n;
      prev_rd   <= bus.rd;

      if (wr_stb && !busy) begin
        if (bus.addr == 2'd0) begin
          cs   <= bus.idata[NUM_CS-1:0];
          mode <= bus.idata[7];
        end else if (bus.addr == 2'd2) begin
          div <= bus.idata[DIV_W-1:0];
        end
      end

      // Legacy mode raises SCLK after the CPU has read the current bit.
      if (rd_stb && bus.addr == 2'd1) begin
        done <= 1'b0;
        ovr  <= 1'b0;
        if (!mode) spi_sclk <= 1'b1;
      end

      if (wr_stb && bus.addr == 2'd1) begin
        if (busy) begin
          ovr <= 1'b1;
        end else if (!mode) begin
          if (spi_sclk) shift[6:0] <= {shift[5:0], spi_miso};
          spi_mosi <= bus.idata[7];
          spi_sclk <= 1'b0;
        end else begin
          shift    <= bus.idata;
          spi_mosi <= bus.idata[7];
          cnt      <= div;
          bitcnt   <= 3'd0;
          busy     <= 1'b1;
          state    <= ST_LOW;
        end
      end

      // The transmit byte shifts out of shift[7] as received bits enter shift[0].
      case (state)
        ST_LOW: begin
          if (cnt == '0) begin
            spi_sclk <= 1'b1;
            shift    <= {shift[6:0], spi_miso};
            cnt      <= div;
            state    <= ST_HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt == '0) begin
            spi_sclk <= 1'b0;
            if (bitcnt == 3'd7) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              spi_mosi <= 1'b1;
            end else begin
              bitcnt   <= bitcnt + 3'd1;
              spi_mosi <= shift[7];
              cnt      <= div;
              state    <= ST_LOW;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rk_spi_port.sv
// Directed bench for rk_spi_port: reset, byte mode with loopback, overrun,
// legacy bit-bang, reset abort and single-strobe behaviour.
module tb_rk_spi_port;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [1:0] spi_cs_n;
  logic       loop_en = 1'b0;
  logic       miso_val = 1'b1;
  int         passed = 0;
  int         total = 0;

  rk_spi_port_if bus();

  rk_spi_port #(.NUM_CS(2), .DIV_W(8), .DEFAULT_DIV(24)) dut (
    .clk50mhz (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  assign spi_miso = loop_en ? spi_mosi : miso_val;

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.addr = a; bus.idata = d; bus.we_n = 1'b0;
    @(negedge clk);
    bus.we_n = 1'b1; bus.sel = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.addr = a; bus.rd = 1'b1;
    #1 d = bus.odata;
    @(negedge clk);
    bus.rd = 1'b0; bus.sel = 1'b0;
  endtask

  task automatic wait_idle(output int cycles, output int rises);
    logic prev;
    cycles = 0;
    rises = 0;
    prev = spi_sclk;
    while (bus.busy && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [7:0] exp_leg [8];
    int cyc, rises, busy_rises, busy_hi;
    logic prevb;

    exp_leg = '{8'h87, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
    bus.sel = 1'b0; bus.addr = 2'd0; bus.idata = 8'h00; bus.we_n = 1'b1; bus.rd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Reset state
    chk("rst_cs_n", spi_cs_n, 2'b11);
    chk("rst_mosi", spi_mosi, 1'b1);
    chk("rst_sclk", spi_sclk, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    bus_rd(2'd3, d); chk("rst_stat", d, 8'h00);
    bus_rd(2'd2, d); chk("rst_div", d, 8'd24);
    bus_rd(2'd0, d); chk("rst_ctrl", d, 8'h00);

    // Byte mode, div=1, loopback
    loop_en = 1'b1;
    bus_wr(2'd2, 8'd1);
    bus_wr(2'd0, 8'h81);
    chk("byte_cs_n", spi_cs_n, 2'b10);
    bus_wr(2'd1, 8'hA5);
    chk("byte_busy_set", bus.busy, 1'b1);
    wait_idle(cyc, rises);
    chk("byte_len", cyc, 32);
    chk("byte_rises", rises, 8);
    chk("byte_sclk_end", spi_sclk, 1'b0);
    chk("byte_mosi_end", spi_mosi, 1'b1);
    bus_rd(2'd3, d); chk("byte_stat_done", d, 8'h02);
    bus_rd(2'd1, d); chk("byte_rx", d, 8'hA5);
    bus_rd(2'd3, d); chk("byte_stat_clr", d, 8'h00);

    // Overrun: writes while busy are dropped
    bus_wr(2'd1, 8'hC3);
    repeat (5) @(posedge clk);
    bus_wr(2'd1, 8'h3C);
    bus_wr(2'd0, 8'h00);
    bus_wr(2'd2, 8'd7);
    bus_rd(2'd3, d); chk("ovr_stat_busy", d, 8'h05);
    wait_idle(cyc, rises);
    chk("ovr_idle", bus.busy, 1'b0);
    bus_rd(2'd3, d); chk("ovr_stat_done", d, 8'h06);
    bus_rd(2'd0, d); chk("ovr_ctrl_kept", d, 8'h81);
    bus_rd(2'd2, d); chk("ovr_div_kept", d, 8'd1);
    bus_rd(2'd1, d); chk("ovr_rx", d, 8'hC3);
    bus_rd(2'd3, d); chk("ovr_stat_clr", d, 8'h00);

    // Legacy bit-bang, miso held high
    loop_en = 1'b0;
    miso_val = 1'b1;
    bus_wr(2'd0, 8'h01);
    bus_rd(2'd0, d); chk("leg_ctrl", d, 8'h01);
    for (int i = 0; i < 8; i++) begin
      bus_wr(2'd1, 8'h80);
      chk($sformatf("leg_mosi_%0d", i), spi_mosi, 1'b1);
      chk($sformatf("leg_sclk_lo_%0d", i), spi_sclk, 1'b0);
      bus_rd(2'd1, d);
      chk($sformatf("leg_rd_%0d", i), d, exp_leg[i]);
      chk($sformatf("leg_sclk_hi_%0d", i), spi_sclk, 1'b1);
    end

    // Reset in the middle of bit 4
    bus_wr(2'd0, 8'h81);
    bus_wr(2'd1, 8'h96);
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_busy", bus.busy, 1'b1);
    chk("abort_pre_sclk", spi_sclk, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_sclk", spi_sclk, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_cs_n", spi_cs_n, 2'b11);
    chk("abort_mosi", spi_mosi, 1'b1);
    @(negedge clk) reset = 1'b0;
    bus_rd(2'd2, d); chk("abort_div", d, 8'd24);
    bus_rd(2'd0, d); chk("abort_ctrl", d, 8'h00);

    // we_n held low for 28 clocks starts a single transfer
    bus_wr(2'd0, 8'h82);
    bus_wr(2'd2, 8'd0);
    @(negedge clk);
    bus.sel = 1'b1; bus.addr = 2'd1; bus.idata = 8'h55; bus.we_n = 1'b0;
    busy_rises = 0;
    busy_hi = 0;
    prevb = bus.busy;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.busy && !prevb) busy_rises++;
      if (bus.busy) busy_hi++;
      prevb = bus.busy;
      if (i == 27) begin
        bus.we_n = 1'b1; bus.sel = 1'b0;
      end
    end
    chk("hold_starts", busy_rises, 1);
    chk("hold_len_div0", busy_hi, 16);
    chk("hold_cs_n", spi_cs_n, 2'b01);
    bus_rd(2'd3, d); chk("hold_stat", d, 8'h02);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
